// File: rtl/position_monitor_if.sv
// Handshake and coordinate bundle between the position-update stage and its consumers.
// master = requester (drives soc_p), slave = position stage (drives eoc_p, x, y).
interface position_monitor_if;
  logic              soc_p;
  logic              eoc_p;
  logic signed [7:0] x;
  logic signed [7:0] y;

  modport master (output soc_p, input eoc_p, input x, input y);
  modport slave  (input soc_p, output eoc_p, output x, output y);
endinterface

// File: rtl/position_monitor.sv
// Periodically requests a position update, accumulates Manhattan distance and flags stalls.
// Optional bounding-box outputs are built when POSITION_MONITOR_BBOX_EN is defined.
module position_monitor #(
  parameter int PERIOD      = 16,
  parameter int STALL_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  position_monitor_if.master  pos,
  output logic                sample_valid,
  output logic [15:0]         step_count,
  output logic [15:0]         distance,
  output logic                stalled
`ifdef POSITION_MONITOR_BBOX_EN
  ,
  output logic signed [7:0]   x_min,
  output logic signed [7:0]   x_max,
  output logic signed [7:0]   y_min,
  output logic signed [7:0]   y_max
`endif
);

  localparam int             TW           = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0]  TIMER_RELOAD = TW'(PERIOD - 1);
  localparam logic [3:0]     STALL_TH     = 4'(STALL_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CALC} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     timer;
  logic              first;
  logic [3:0]        stall_cnt;
  logic signed [7:0] prev_x, prev_y;

  logic signed [8:0] dx, dy;
  logic [9:0]        step_dist;
  logic [3:0]        stall_nxt;

  function automatic logic [8:0] abs9(input logic signed [8:0] v);
    logic [8:0] r;
    r = v[8] ? -v : v;
    return r;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [9:0] inc);
    logic [16:0] s;
    s = {1'b0, acc} + {7'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // soc_p is a pure decode of the state so reset clears it without waiting for an edge.
  always_comb begin
    state_nxt = state;
    pos.soc_p = 1'b0;
    case (state)
      IDLE: if (enable && timer == '0) state_nxt = REQ;
      REQ: begin
        pos.soc_p = 1'b1;
        if (!pos.eoc_p) state_nxt = WAIT;
      end
      WAIT: if (pos.eoc_p) state_nxt = CALC;
      CALC: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sign-extended differences never overflow 9 bits, so |dx|+|dy| fits in 10.
  always_comb begin
    dx        = {pos.x[7], pos.x} - {prev_x[7], prev_x};
    dy        = {pos.y[7], pos.y} - {prev_y[7], prev_y};
    step_dist = {1'b0, abs9(dx)} + {1'b0, abs9(dy)};
    stall_nxt = (pos.x == prev_x && pos.y == prev_y) ? sat_inc4(stall_cnt) : 4'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer        <= TIMER_RELOAD;
      first        <= 1'b1;
      stall_cnt    <= 4'd0;
      prev_x       <= 8'sd0;
      prev_y       <= 8'sd0;
      sample_valid <= 1'b0;
      step_count   <= 16'd0;
      distance     <= 16'd0;
      stalled      <= 1'b0;
`ifdef POSITION_MONITOR_BBOX_EN
      x_min        <= 8'sh7F;
      x_max        <= 8'sh80;
      y_min        <= 8'sh7F;
      y_max        <= 8'sh80;
`endif
    end else begin
      sample_valid <= 1'b0;
      if (state == IDLE && enable && timer != '0) timer <= timer - TW'(1);
      if (state == CALC) begin
        timer        <= TIMER_RELOAD;
        prev_x       <= pos.x;
        prev_y       <= pos.y;
        step_count   <= step_count + 16'd1;
        sample_valid <= 1'b1;
        first        <= 1'b0;
        // The first sample only establishes a reference point.
        if (!first) begin
          distance  <= sat_add16(distance, step_dist);
          stall_cnt <= stall_nxt;
          stalled   <= (stall_nxt >= STALL_TH);
        end
`ifdef POSITION_MONITOR_BBOX_EN
        if (first || pos.x < x_min) x_min <= pos.x;
        if (first || pos.x > x_max) x_max <= pos.x;
        if (first || pos.y < y_min) y_min <= pos.y;
        if (first || pos.y > y_max) y_max <= pos.y;
`endif
      end
    end
  end

endmodule

// File: tb/tb_position_monitor.sv
// Directed-plus-random bench for position_monitor with an arithmetic reference model.
module tb_position_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_valid;
  logic [15:0] step_count;
  logic [15:0] distance;
  logic        stalled;
`ifdef POSITION_MONITOR_BBOX_EN
  logic signed [7:0] x_min, x_max, y_min, y_max;
`endif

  position_monitor_if pos ();

  position_monitor #(.PERIOD(16), .STALL_LIMIT(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .pos          (pos.master),
    .sample_valid (sample_valid),
    .step_count   (step_count),
    .distance     (distance),
    .stalled      (stalled)
`ifdef POSITION_MONITOR_BBOX_EN
    ,
    .x_min        (x_min),
    .x_max        (x_max),
    .y_min        (y_min),
    .y_max        (y_max)
`endif
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  // Reference model state, plain integers.
  int m_px, m_py, m_first, m_steps, m_dist, m_stall, m_stalled;
  int m_xmin, m_xmax, m_ymin, m_ymax;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_px = 0; m_py = 0; m_first = 1; m_steps = 0; m_dist = 0;
    m_stall = 0; m_stalled = 0;
    m_xmin = 127; m_xmax = -128; m_ymin = 127; m_ymax = -128;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_sample(input int xv, input int yv);
    if (m_first) begin
      m_first = 0;
    end else begin
      m_dist = m_dist + iabs(xv - m_px) + iabs(yv - m_py);
      if (m_dist > 65535) m_dist = 65535;
      if (xv == m_px && yv == m_py) m_stall = (m_stall < 15) ? m_stall + 1 : 15;
      else m_stall = 0;
      m_stalled = (m_stall >= 4) ? 1 : 0;
    end
    m_steps = (m_steps + 1) % 65536;
    m_px = xv; m_py = yv;
    if (xv < m_xmin) m_xmin = xv;
    if (xv > m_xmax) m_xmax = xv;
    if (yv < m_ymin) m_ymin = yv;
    if (yv > m_ymax) m_ymax = yv;
  endtask

  // Present a position, wait for the monitor to register it, compare with the model.
  task automatic sample(input int xv, input int yv);
    int seen;
    pos.x = 8'(xv);
    pos.y = 8'(yv);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (sample_valid) begin
        seen = 1;
        break;
      end
    end
    check("sample_seen", 32'(seen), 32'd1);
    model_sample(xv, yv);
    check("step_count", {16'd0, step_count}, 32'(m_steps));
    check("distance",   {16'd0, distance},   32'(m_dist));
    check("stalled",    {31'd0, stalled},    32'(m_stalled));
    @(negedge clock);
    check("valid_one_cycle", {31'd0, sample_valid}, 32'd0);
  endtask

`ifdef POSITION_MONITOR_BBOX_EN
  task automatic check_bbox();
    logic [7:0] e;
    e = 8'(m_xmin); check("x_min", {24'd0, x_min}, {24'd0, e});
    e = 8'(m_xmax); check("x_max", {24'd0, x_max}, {24'd0, e});
    e = 8'(m_ymin); check("y_min", {24'd0, y_min}, {24'd0, e});
    e = 8'(m_ymax); check("y_max", {24'd0, y_max}, {24'd0, e});
  endtask
`endif

  // Position stage stand-in: drop eoc_p 2 cycles after soc_p, raise it 3 cycles later.
  initial begin
    pos.eoc_p = 1'b1;
    forever begin
      @(posedge pos.soc_p);
      repeat (2) @(negedge clock);
      pos.eoc_p = 1'b0;
      repeat (3) @(negedge clock);
      pos.eoc_p = 1'b1;
    end
  end

  initial begin
    int cnt;
    int hits;
    int base;
    int xv, yv;
    reset  = 1'b1;
    enable = 1'b0;
    pos.x  = 8'sd5;
    pos.y  = -8'sd3;
    model_reset();
    repeat (3) @(negedge clock);

    check("rst_soc_p",  {31'd0, pos.soc_p},    32'd0);
    check("rst_valid",  {31'd0, sample_valid}, 32'd0);
    check("rst_steps",  {16'd0, step_count},   32'd0);
    check("rst_dist",   {16'd0, distance},     32'd0);
    check("rst_stalled",{31'd0, stalled},      32'd0);
`ifdef POSITION_MONITOR_BBOX_EN
    check_bbox();
`endif
    reset = 1'b0;
    @(negedge clock);

    // First request latency after enable.
    enable = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (pos.soc_p) begin
        cnt = i;
        break;
      end
    end
    check("soc_latency", 32'(cnt), 32'd16);
    sample(5, -3);
    sample(8, 1);

    // Extreme coordinate swing.
    sample(127, -128);
    base = m_dist;
    sample(-128, 127);
    check("wrap_delta", 32'(m_dist - base), 32'd510);

    // Hold position: stalled after the 4th unchanged sample, cleared by movement.
    for (int i = 0; i < 4; i++) sample(-128, 127);
    check("stalled_after_4", {31'd0, stalled}, 32'd1);
    sample(0, 0);
    check("stalled_cleared", {31'd0, stalled}, 32'd0);

    // Random walk with occasional repeats.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        xv = m_px; yv = m_py;
      end else begin
        xv = int'($urandom_range(0, 255)) - 128;
        yv = int'($urandom_range(0, 255)) - 128;
      end
      sample(xv, yv);
    end

    // Drive distance into saturation.
    for (int i = 0; i < 200 && m_dist < 65535; i++) begin
      if (i % 2 == 0) sample(127, -128);
      else            sample(-128, 127);
    end
    check("dist_saturated", {16'd0, distance}, 32'h0000FFFF);
    sample(m_px == 127 ? -128 : 127, m_py == 127 ? -128 : 127);
    check("dist_stays_sat", {16'd0, distance}, 32'h0000FFFF);

    // Disable during the handshake: it still completes, then no more requests.
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!pos.eoc_p) begin
        cnt = 1;
        break;
      end
    end
    check("reached_wait", 32'(cnt), 32'd1);
    enable = 1'b0;
    sample(10, 20);
    hits = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (pos.soc_p) hits++;
    end
    check("no_soc_when_off", 32'(hits), 32'd0);

    // Asynchronous reset while soc_p is high.
    enable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (pos.soc_p) begin
        cnt = 1;
        break;
      end
    end
    check("soc_before_reset", 32'(cnt), 32'd1);
    enable = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_soc_p",   {31'd0, pos.soc_p},    32'd0);
    check("async_steps",   {16'd0, step_count},   32'd0);
    check("async_dist",    {16'd0, distance},     32'd0);
    check("async_stalled", {31'd0, stalled},      32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);

    // Fresh run after reset: bounding box and first-sample behaviour.
    enable = 1'b1;
    sample(3, 3);
    sample(-2, 10);
    sample(7, -1);
`ifdef POSITION_MONITOR_BBOX_EN
    check_bbox();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/position_monitor.md
Name: position_monitor

Overview:
- Downstream consumer of the position-update stage. That stage exposes the soc_p/eoc_p handshake and the 8-bit signed x, y coordinates.
- At a programmable interval this block requests a position update, samples the new (x, y) and accumulates Manhattan distance travelled.
- Counts completed updates and flags a stalled object: an object whose position has not changed for a programmable number of consecutive updates (e.g. blocked by overflow clamping).

Parameters:
- PERIOD, 16: idle cycles between the end of one update and the next soc_p assertion (>=1).
- STALL_LIMIT, 4: consecutive unchanged samples before stalled asserts (1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = issue periodic update requests.
- soc_p  out  1  start-of-conversion to position stage.
- eoc_p  in  1  end-of-conversion from position stage.
- x  in  8  current x, two's complement.
- y  in  8  current y, two's complement.
- sample_valid  out  1  one-cycle pulse when a new sample is registered.
- step_count  out  16  completed updates, wraps.
- distance  out  16  accumulated |dx|+|dy|, saturating.
- stalled  out  1  position unchanged for >= STALL_LIMIT consecutive samples.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high; ports are named clock and reset.
- Reset values:
  - state = IDLE, soc_p = 0, sample_valid = 0.
  - step_count = 0, distance = 0, stalled = 0.
  - timer = PERIOD-1, stall counter = 0, first flag = 1.
  - prev_x = prev_y = 0.
- Reset asserted mid-handshake aborts immediately to these values. The upstream stage is responsible for its own recovery.
- FSM states:
  - IDLE:
    - soc_p = 0.
    - If enable = 1 and timer != 0: timer decrements.
    - If enable = 1 and timer = 0: go to REQ.
    - If enable = 0: timer holds.
  - REQ:
    - soc_p = 1.
    - Stay while eoc_p = 1; on eoc_p = 0 go to WAIT.
  - WAIT:
    - soc_p = 0.
    - Stay while eoc_p = 0; on eoc_p = 1 go to CALC.
  - CALC (one cycle):
    - Register x, y into prev_x/prev_y.
    - Update counters and pulse sample_valid on the next edge.
    - Reload timer to PERIOD-1, return to IDLE.
- enable deasserted during REQ/WAIT does not abort; the handshake completes and the sample is taken. enable is only examined in IDLE.
- Latency: soc_p rises on the clock edge after timer reaches 0. sample_valid is high the cycle after CALC.
- Arithmetic in CALC:
  - dx = sign-extend-9(x) - sign-extend-9(prev_x); dy likewise.
  - |dx|, |dy| <= 255 each; the 10-bit sum is zero-extended and added to distance.
  - distance saturates at 16'hFFFF and never wraps.
  - step_count increments by 1 and wraps FFFF -> 0000.
- First sample after reset (first flag = 1):
  - Only latches prev_x/prev_y, increments step_count and pulses sample_valid.
  - Does not change distance or the stall counter; clears first flag.
- Stall logic (non-first sample):
  - If x == prev_x and y == prev_y: stall counter increments, saturating at 15.
  - Otherwise: stall counter clears to 0.
  - stalled = (stall counter >= STALL_LIMIT), registered and updated together with sample_valid.
  - Movement deasserts stalled in the same update.

Optional Feature:
- Macro POSITION_MONITOR_BBOX_EN.
- When defined:
  - Adds outputs x_min, x_max, y_min, y_max (8 bits each, signed compare).
  - These are updated on every sample, including the first, which initialises all four to the sample.
  - Reset value: min = 8'h7F, max = 8'h80.
- When undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then enable = 1, PERIOD = 16, with a responder that drops eoc_p 2 cycles after soc_p and raises it 3 cycles later, x = 5, y = -3 -> soc_p first rises 16 cycles after enable; sample_valid pulses once; step_count = 1, distance = 0.
- Second sample x = 8, y = 1 after (5, -3) -> distance = 3 + 4 = 7, step_count = 2.
- Sample wrap case: (127, -128) then (-128, 127) -> distance increases by 255 + 255 = 510.
- Position held constant for 4 samples with STALL_LIMIT = 4 -> stalled = 1 after the 4th unchanged sample; next sample at a new position -> stalled = 0, stall counter 0.
- enable = 0 while in WAIT -> handshake completes, one sample taken, then no further soc_p; async reset while soc_p = 1 -> soc_p = 0 with no clock edge, all counters 0.
- Preload distance = FFF0, then move by 40 -> distance = FFFF. With POSITION_MONITOR_BBOX_EN, samples (3, 3), (-2, 10), (7, -1) -> x_min = -2, x_max = 7, y_min = -1, y_max = 10.
